// File: rtl/can_rx_packer.sv
// Stages one received CAN/CAN FD frame (header plus up to 64 data bytes) and, once the
// frame is validated, writes it to the RX FIFO as one contiguous burst of 32-bit words.
module can_rx_packer #(
    parameter int MAX_WORDS = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reset_mode_i,
    input  logic        sof_i,
    input  logic        hdr_valid_i,
    input  logic [28:0] id_i,
    input  logic        ide_i,
    input  logic        rtr_i,
    input  logic        fdf_i,
    input  logic        brs_i,
    input  logic        esi_i,
    input  logic [3:0]  dlc_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    input  logic        frame_ok_i,
    input  logic        frame_err_i,
    output logic        wr_o,
    output logic [31:0] data_in_o,
    output logic        busy_o,
    output logic        drop_o,
    output logic [1:0]  drop_cause_o
);
    // state | meaning
    // IDLE  | waiting for sof
    // HDR   | frame started, waiting for header fields
    // DATA  | collecting bytes until frame_ok / frame_err
    // BURST | streaming the validated message into the FIFO
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_BURST} state_t;

    localparam logic [4:0] MAX_W = 5'(MAX_WORDS);

    state_t          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d, cnt_inc, exp_bytes;
    logic [4:0]      idx_q, idx_d, words;
    logic [28:0]     id_q, id_d;
    logic [4:0]      fmt_q, fmt_d;   // {fdf, brs, esi, ide, rtr}
    logic [3:0]      dlc_q, dlc_d;
    logic            wr_q, wr_d, drop_q, drop_d;
    logic [1:0]      cause_q, cause_d;
    logic [31:0]     data_q, data_d, word_sel;
    logic [3:0][7:0] mem_q [16];
    logic            mem_clr, mem_wr;
    logic [3:0]      data_idx;

    always_comb begin
        exp_bytes = 7'd0;
        if (fmt_q[0] && !fmt_q[4]) begin
            exp_bytes = 7'd0;
        end else if (dlc_q <= 4'd8) begin
            exp_bytes = {3'b000, dlc_q};
        end else if (!fmt_q[4]) begin
            exp_bytes = 7'd8;
        end else begin
            case (dlc_q)
                4'd9:    exp_bytes = 7'd12;
                4'd10:   exp_bytes = 7'd16;
                4'd11:   exp_bytes = 7'd20;
                4'd12:   exp_bytes = 7'd24;
                4'd13:   exp_bytes = 7'd32;
                4'd14:   exp_bytes = 7'd48;
                default: exp_bytes = 7'd64;
            endcase
        end
    end

    assign words    = 5'd2 + 5'((exp_bytes + 7'd3) >> 2);
    assign cnt_inc  = (byte_valid_i && cnt_q != 7'd127) ? cnt_q + 7'd1 : cnt_q;
    assign data_idx = 4'(idx_q - 5'd2);

    always_comb begin
        case (idx_q)
            5'd0:    word_sel = {23'h0, fmt_q, dlc_q};
            5'd1:    word_sel = fmt_q[1] ? {3'h0, id_q} : {21'h0, id_q[10:0]};
            default: word_sel = mem_q[data_idx];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        id_d    = id_q;
        fmt_d   = fmt_q;
        dlc_d   = dlc_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        drop_d  = 1'b0;
        cause_d = cause_q;
        mem_clr = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sof_i) begin
                    state_d = S_HDR;
                    cnt_d   = 7'd0;
                    mem_clr = 1'b1;
                end
            end
            S_HDR: begin
                if (frame_err_i) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b1;
                    cause_d = 2'd0;
                end else if (frame_ok_i) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b1;
                    cause_d = 2'd1;
                end else if (sof_i) begin
                    cnt_d   = 7'd0;
                    mem_clr = 1'b1;
                    drop_d  = 1'b1;
                    cause_d = 2'd0;
                end else if (hdr_valid_i) begin
                    state_d = S_DATA;
                    id_d    = id_i;
                    fmt_d   = {fdf_i, brs_i, esi_i, ide_i, rtr_i};
                    dlc_d   = dlc_i;
                end
            end
            S_DATA: begin
                mem_wr = byte_valid_i && (cnt_q < exp_bytes);
                cnt_d  = cnt_inc;
                if (frame_err_i) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b1;
                    cause_d = 2'd0;
                end else if (frame_ok_i) begin
                    if (cnt_inc != exp_bytes) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b1;
                        cause_d = 2'd1;
                    end else if (words > MAX_W) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b1;
                        cause_d = 2'd2;
                    end else begin
                        state_d = S_BURST;
                        idx_d   = 5'd0;
                    end
                end else if (sof_i) begin
                    state_d = S_HDR;
                    cnt_d   = 7'd0;
                    mem_clr = 1'b1;
                    drop_d  = 1'b1;
                    cause_d = 2'd0;
                end
            end
            S_BURST: begin
                wr_d   = 1'b1;
                data_d = word_sel;
                idx_d  = idx_q + 5'd1;
                if (idx_q == words - 5'd1) begin
                    state_d = S_IDLE;
                end
                if (sof_i) begin
                    drop_d  = 1'b1;
                    cause_d = 2'd3;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || reset_mode_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            idx_q   <= 5'd0;
            id_q    <= 29'd0;
            fmt_q   <= 5'd0;
            dlc_q   <= 4'd0;
            wr_q    <= 1'b0;
            data_q  <= 32'd0;
            drop_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            fmt_q   <= fmt_d;
            dlc_q   <= dlc_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            cause_q <= cause_d;
        end
    end

    // Cleared at every frame start so bytes beyond the last received one read back as 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || reset_mode_i || mem_clr) begin
            for (int w = 0; w < 16; w++) begin
                mem_q[w] <= '0;
            end
        end else if (mem_wr) begin
            mem_q[cnt_q[5:2]][cnt_q[1:0]] <= byte_data_i;
        end
    end

    assign wr_o         = wr_q;
    assign data_in_o    = data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign drop_o       = drop_q;
    assign drop_cause_o = cause_q;
endmodule
